// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - instruction-memory request/ack bus between fetch and memory
interface instruction_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - single-outstanding fetch stage with skid buffer, IF/ID register
// and delay-slot-preserving redirect (pending / squash) handling.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall,
  input  logic                       jump_branch,
  input  logic                       jump_target,
  input  logic                       jump_reg,
  input  logic [31:0]                b_addr,
  input  logic [31:0]                jr_pc,
  instruction_fetch_if.master        imem,
  output logic [31:0]                pc_id,
  output logic [31:0]                instr_id,
  output logic                       valid_id
);

  typedef enum logic [1:0] {IDLE, WAIT, FULL} state_t;

  state_t      state, state_next;
  logic [31:0] fetch_pc, fetch_pc_next;
  logic [31:0] skid_pc, skid_instr;
  logic [31:0] redirect_target, target_next;
  logic        redirect_pending, pending_next;
  logic        squash, squash_next;
  logic        id_from_mem, id_from_skid, id_bubble, skid_load;

  logic [31:0] pc_plus4, pc_plus8, raw_target, new_target;
  logic        resolve, slot_unfetched, slot_fetched;

  assign pc_plus4 = pc_id + 32'd4;
  assign pc_plus8 = pc_id + 32'd8;
  assign resolve  = valid_id & (jump_reg | jump_target | jump_branch) & ~stall;

  always_comb begin
    raw_target = b_addr;
    if (jump_reg)
      raw_target = jr_pc;
    else if (jump_target)
      raw_target = {pc_plus4[31:28], instr_id[25:0], 2'b00};
  end

  assign new_target = {raw_target[31:2], 2'b00};

  // Where the delay slot stands decides how the redirect is applied.
  assign slot_unfetched = resolve & (fetch_pc == pc_plus4);
  assign slot_fetched   = resolve & (fetch_pc == pc_plus8);

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    target_next   = resolve ? new_target : redirect_target;
    pending_next  = redirect_pending;
    squash_next   = squash;
    id_from_mem   = 1'b0;
    id_from_skid  = 1'b0;
    id_bubble     = 1'b0;
    skid_load     = 1'b0;

    case (state)
      IDLE: begin
        state_next = WAIT;
        id_bubble  = ~stall;
      end
      WAIT: begin
        if (imem.imem_ack) begin
          if (squash | slot_fetched) begin
            fetch_pc_next = target_next;
            squash_next   = 1'b0;
            id_bubble     = ~stall;
          end else begin
            fetch_pc_next = (redirect_pending | slot_unfetched) ? target_next
                                                                : fetch_pc + 32'd4;
            pending_next  = 1'b0;
            if (stall) begin
              skid_load  = 1'b1;
              state_next = FULL;
            end else begin
              id_from_mem = 1'b1;
            end
          end
        end else begin
          id_bubble = ~stall;
          if (slot_unfetched) pending_next = 1'b1;
          if (slot_fetched)   squash_next  = 1'b1;
        end
      end
      FULL: begin
        if (!stall) begin
          id_from_skid = 1'b1;
          state_next   = WAIT;
          if (slot_fetched)   fetch_pc_next = new_target;
          if (slot_unfetched) pending_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      fetch_pc         <= RESET_PC;
      pc_id            <= RESET_PC;
      instr_id         <= 32'h0;
      valid_id         <= 1'b0;
      skid_pc          <= 32'h0;
      skid_instr       <= 32'h0;
      redirect_target  <= 32'h0;
      redirect_pending <= 1'b0;
      squash           <= 1'b0;
    end else begin
      state            <= state_next;
      fetch_pc         <= fetch_pc_next;
      redirect_target  <= target_next;
      redirect_pending <= pending_next;
      squash           <= squash_next;
      if (skid_load) begin
        skid_pc    <= fetch_pc;
        skid_instr <= imem.imem_rdata;
      end
      // A bubble leaves pc_id alone so decode still sees the last real PC.
      if (id_from_mem) begin
        pc_id    <= fetch_pc;
        instr_id <= imem.imem_rdata;
        valid_id <= 1'b1;
      end else if (id_from_skid) begin
        pc_id    <= skid_pc;
        instr_id <= skid_instr;
        valid_id <= 1'b1;
      end else if (id_bubble) begin
        instr_id <= 32'h0;
        valid_id <= 1'b0;
      end
    end
  end

  assign imem.imem_req  = (state == WAIT);
  assign imem.imem_addr = {fetch_pc[31:2], 2'b00};

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed bench for instruction_fetch: reset, stall/skid,
// beq/jr/j redirects with delay slots, reset mid-request.
module tb_instruction_fetch;
  localparam logic [31:0] RST_PC   = 32'h0040_0000;
  localparam logic [31:0] BEQ_WORD = 32'h1000_003B;
  localparam logic [31:0] JR_WORD  = 32'h0320_0008;
  localparam logic [31:0] J_WORD   = 32'h0800_0040;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] b_addr = 32'h0040_0100;
  logic [31:0] jr_pc = 32'h0040_0200;
  logic        jump_branch, jump_target, jump_reg;
  logic [31:0] pc_id, instr_id;
  logic        valid_id;

  int   lat = 0;
  int   wait_cnt = 0;
  logic stray = 1'b0;
  logic beq_en = 1'b1;
  logic jr_en = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] cons_pc[$];
  logic [31:0] cons_instr[$];
  logic [31:0] acked[$];
  logic        prev_hold = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  logic [31:0] exp_a [8] = '{32'h0040_0000, 32'h0040_0004, 32'h0040_0008, 32'h0040_000C,
                             32'h0040_0010, 32'h0040_0014, 32'h0040_0100, 32'h0040_0104};
  logic [31:0] exp_b [18] = '{32'h0040_0000, 32'h0040_0004, 32'h0040_0008, 32'h0040_000C,
                              32'h0040_0010, 32'h0040_0014, 32'h0040_0018, 32'h0040_001C,
                              32'h0040_0020, 32'h0040_0024, 32'h0040_0200, 32'h0040_0204,
                              32'h0040_0208, 32'h0040_020C, 32'h0FFF_FFF8, 32'h0FFF_FFFC,
                              32'h1000_0000, 32'h1000_0100};

  instruction_fetch_if bus();

  instruction_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .jump_branch (jump_branch),
    .jump_target (jump_target),
    .jump_reg    (jump_reg),
    .b_addr      (b_addr),
    .jr_pc       (jr_pc),
    .imem        (bus.master),
    .pc_id       (pc_id),
    .instr_id    (instr_id),
    .valid_id    (valid_id)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic be, input logic je);
    if (a == 32'h0040_0010 && be) return BEQ_WORD;
    if ((a == 32'h0040_0020 || a == 32'h0040_0208) && je) return JR_WORD;
    if (a == 32'h0FFF_FFFC) return J_WORD;
    return a;
  endfunction

  assign bus.imem_ack   = (bus.imem_req && (wait_cnt >= lat)) || stray;
  assign bus.imem_rdata = stray ? 32'hDEAD_BEEF : mem_word(bus.imem_addr, beq_en, jr_en);

  assign jump_branch = (instr_id == BEQ_WORD);
  assign jump_reg    = (instr_id == JR_WORD);
  assign jump_target = (instr_id == J_WORD);

  always @(posedge clk) begin
    if (!bus.imem_req || bus.imem_ack) wait_cnt <= 0;
    else                               wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int count_addr(input logic [31:0] a);
    int c = 0;
    foreach (acked[i]) if (acked[i] == a) c++;
    return c;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_hold) begin
        chk("req_held", {31'b0, bus.imem_req}, 32'd1);
        chk("addr_held", bus.imem_addr, prev_addr);
      end
      if (bus.imem_req) chk("addr_aligned", {30'b0, bus.imem_addr[1:0]}, 32'd0);
      if (bus.imem_req && bus.imem_ack) acked.push_back(bus.imem_addr);
      if (valid_id && !stall) begin
        cons_pc.push_back(pc_id);
        cons_instr.push_back(instr_id);
        if (jump_reg || jump_target || jump_branch)
          chk("no_xfer_in_slot", {30'b0, dut.redirect_pending, dut.squash}, 32'd0);
      end
    end
    prev_hold <= rst_n && bus.imem_req && !bus.imem_ack;
    prev_addr <= bus.imem_addr;
  end

  initial begin
    int g;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_valid", {31'b0, valid_id}, 32'd0);
    chk("rst_pc_id", pc_id, RST_PC);
    chk("rst_instr", instr_id, 32'h0);
    chk("rst_addr", bus.imem_addr, RST_PC);

    rst_n = 1'b1;
    tick();
    chk("first_req", {31'b0, bus.imem_req}, 32'd1);
    chk("first_addr", bus.imem_addr, 32'h0040_0000);
    chk("valid_after1", {31'b0, valid_id}, 32'd0);
    tick();
    chk("valid_after2", {31'b0, valid_id}, 32'd1);
    chk("pc_after2", pc_id, 32'h0040_0000);
    chk("instr_after2", instr_id, 32'h0040_0000);
    chk("addr_after2", bus.imem_addr, 32'h0040_0004);
    tick();
    chk("pc_after3", pc_id, 32'h0040_0004);
    chk("addr_after3", bus.imem_addr, 32'h0040_0008);

    stall = 1'b1;
    tick();
    chk("skid_full_req", {31'b0, bus.imem_req}, 32'd0);
    chk("stall_instr", instr_id, 32'h0040_0004);
    tick();
    tick();
    chk("stall_hold_instr", instr_id, 32'h0040_0004);
    chk("stall_hold_req", {31'b0, bus.imem_req}, 32'd0);
    stall = 1'b0;
    tick();
    chk("skid_out_pc", pc_id, 32'h0040_0008);
    chk("skid_out_instr", instr_id, 32'h0040_0008);
    chk("skid_out_valid", {31'b0, valid_id}, 32'd1);
    chk("resume_addr", bus.imem_addr, 32'h0040_000C);
    chk("resume_req", {31'b0, bus.imem_req}, 32'd1);
    tick();
    chk("pc_0c", pc_id, 32'h0040_000C);
    chk("addr_10", bus.imem_addr, 32'h0040_0010);

    lat = 3;
    g = 0;
    while (cons_pc.size() < 8 && g < 200) begin tick(); g++; end
    chk("segA_count", {31'b0, cons_pc.size() >= 8}, 32'd1);
    for (int i = 0; i < 8; i++)
      chk($sformatf("segA_pc%0d", i), (i < cons_pc.size()) ? cons_pc[i] : 32'hxxxx_xxxx, exp_a[i]);
    chk("beq_instr", (cons_instr.size() > 4) ? cons_instr[4] : 32'hxxxx_xxxx, BEQ_WORD);
    chk("beq_no_0x18", count_addr(32'h0040_0018), 32'd0);

    g = 0;
    while (!(bus.imem_req && !bus.imem_ack) && g < 50) begin tick(); g++; end
    chk("pre_reset_wait", {31'b0, bus.imem_req && !bus.imem_ack}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", {31'b0, bus.imem_req}, 32'd0);
    chk("async_valid", {31'b0, valid_id}, 32'd0);
    chk("async_pc_id", pc_id, RST_PC);
    chk("async_instr", instr_id, 32'h0);
    chk("async_addr", bus.imem_addr, RST_PC);
    cons_pc.delete();
    cons_instr.delete();
    acked.delete();
    @(posedge clk);
    #1;
    stray = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    stray = 1'b0;
    chk("stray_addr", bus.imem_addr, RST_PC);
    chk("stray_req", {31'b0, bus.imem_req}, 32'd1);
    chk("stray_valid", {31'b0, valid_id}, 32'd0);
    chk("stray_instr", instr_id, 32'h0);

    lat = 1;
    beq_en = 1'b0;
    jr_en = 1'b1;
    g = 0;
    while (!(valid_id && pc_id == 32'h0040_0020) && g < 100) begin tick(); g++; end
    chk("jr_reached", {31'b0, valid_id && pc_id == 32'h0040_0020}, 32'd1);
    stall = 1'b1;
    repeat (4) tick();
    chk("jr_full_req", {31'b0, bus.imem_req}, 32'd0);
    chk("jr_held_instr", instr_id, JR_WORD);
    chk("jr_held_pc", pc_id, 32'h0040_0020);
    stall = 1'b0;
    tick();
    chk("jr_slot_pc", pc_id, 32'h0040_0024);
    chk("jr_next_addr", bus.imem_addr, 32'h0040_0200);
    chk("jr_next_req", {31'b0, bus.imem_req}, 32'd1);

    lat = 0;
    jr_pc = 32'h0FFF_FFF8;
    g = 0;
    while (cons_pc.size() < 18 && g < 300) begin tick(); g++; end
    chk("segB_count", {31'b0, cons_pc.size() >= 18}, 32'd1);
    for (int i = 0; i < 18; i++)
      chk($sformatf("segB_pc%0d", i), (i < cons_pc.size()) ? cons_pc[i] : 32'hxxxx_xxxx, exp_b[i]);
    chk("jr_instr", (cons_instr.size() > 8) ? cons_instr[8] : 32'hxxxx_xxxx, JR_WORD);
    chk("j_instr", (cons_instr.size() > 15) ? cons_instr[15] : 32'hxxxx_xxxx, J_WORD);
    chk("jr_no_0x28", count_addr(32'h0040_0028), 32'd0);
    chk("jr2_no_0x210", count_addr(32'h0040_0210), 32'd0);
    chk("j_no_seq", count_addr(32'h1000_0004), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
